updn_counter_param: RTL and testbench

UPDN_COUNTER_PARAM -- requirements
Module: updn_counter_param

---
 rtl/updn_counter_param.sv | 92 +++++++++
 tb/tb_updn_counter_param.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/updn_counter_param.sv
// Parameterised up/down counter with modulus MAX_VAL+1, wrap or saturate at the
// boundaries, terminal-count pulse, sticky overflow/underflow flags and compare.
module updn_counter_param #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter bit              SAT     = 1'b0
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             ltn,
  input  logic             upn_down,
  input  logic             en,
  input  logic [WIDTH-1:0] load,
  input  logic [WIDTH-1:0] cmp,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] dout,
  output logic             oe,
  output logic             tc,
  output logic             ovf,
  output logic             unf,
  output logic             match
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             oe_q, oe_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Next-state: load beats count beats hold; a boundary set beats flag_clr.
  always_comb begin
    dout_d = dout_q;
    oe_d   = oe_q;
    tc_d   = 1'b0;
    ovf_d  = ovf_q & ~flag_clr;
    unf_d  = unf_q & ~flag_clr;
    if (!ltn) begin
      oe_d   = 1'b1;
      dout_d = (load > MAX_VAL) ? MAX_VAL : load;
    end else if (en) begin
      oe_d = 1'b1;
      if (!upn_down) begin
        if (dout_q == MAX_VAL) begin
          tc_d   = 1'b1;
          ovf_d  = 1'b1;
          dout_d = SAT ? MAX_VAL : ZERO;
        end else begin
          dout_d = dout_q + ONE;
        end
      end else begin
        if (dout_q == ZERO) begin
          tc_d   = 1'b1;
          unf_d  = 1'b1;
          dout_d = SAT ? ZERO : MAX_VAL;
        end else begin
          dout_d = dout_q - ONE;
        end
      end
    end else begin
      dout_d = dout_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      dout_q <= ZERO;
      oe_q   <= 1'b0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      oe_q   <= oe_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign dout  = dout_q;
  assign oe    = oe_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  // dout is bounded by MAX_VAL, so an out-of-range cmp can never match.
  assign match = (dout_q == cmp);

endmodule

// File: tb/tb_updn_counter_param.sv
// Bench for updn_counter_param: a wrap instance and a saturate instance (WIDTH=4,
// MAX_VAL=9) share stimulus and are compared against an integer reference model.
module tb_updn_counter_param;

  localparam int W   = 4;
  localparam int MAX = 9;

  logic         clk = 1'b0;
  logic         arstn, ltn, upn_down, en, flag_clr;
  logic [W-1:0] load, cmp;
  logic [W-1:0] dout_w, dout_s;
  logic         oe_w, tc_w, ovf_w, unf_w, match_w;
  logic         oe_s, tc_s, ovf_s, unf_s, match_s;

  int n_chk = 0;
  int n_err = 0;

  int m_dout [2];
  bit m_oe [2], m_tc [2], m_ovf [2], m_unf [2];

  always #5 clk = ~clk;

  updn_counter_param #(.WIDTH(W), .MAX_VAL(4'd9), .SAT(1'b0)) u_wrap (
    .clk(clk), .arstn(arstn), .ltn(ltn), .upn_down(upn_down), .en(en),
    .load(load), .cmp(cmp), .flag_clr(flag_clr), .dout(dout_w), .oe(oe_w),
    .tc(tc_w), .ovf(ovf_w), .unf(unf_w), .match(match_w)
  );

  updn_counter_param #(.WIDTH(W), .MAX_VAL(4'd9), .SAT(1'b1)) u_sat (
    .clk(clk), .arstn(arstn), .ltn(ltn), .upn_down(upn_down), .en(en),
    .load(load), .cmp(cmp), .flag_clr(flag_clr), .dout(dout_s), .oe(oe_s),
    .tc(tc_s), .ovf(ovf_s), .unf(unf_s), .match(match_s)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_dout[s] = 0; m_oe[s] = 1'b0; m_tc[s] = 1'b0; m_ovf[s] = 1'b0; m_unf[s] = 1'b0;
    end
  endtask

  // One rising edge: step the count by +/-1 and fold out-of-range results back.
  task automatic model_edge();
    int nxt;
    bit ev_o, ev_u;
    for (int s = 0; s < 2; s++) begin
      ev_o = 1'b0;
      ev_u = 1'b0;
      m_tc[s] = 1'b0;
      if (!ltn) begin
        m_oe[s]   = 1'b1;
        m_dout[s] = (int'(load) > MAX) ? MAX : int'(load);
      end else if (en) begin
        m_oe[s] = 1'b1;
        nxt = upn_down ? m_dout[s] - 1 : m_dout[s] + 1;
        if (nxt > MAX) begin
          ev_o = 1'b1; m_tc[s] = 1'b1;
          m_dout[s] = (s == 1) ? MAX : 0;
        end else if (nxt < 0) begin
          ev_u = 1'b1; m_tc[s] = 1'b1;
          m_dout[s] = (s == 1) ? 0 : MAX;
        end else begin
          m_dout[s] = nxt;
        end
      end
      m_ovf[s] = (m_ovf[s] && !flag_clr) || ev_o;
      m_unf[s] = (m_unf[s] && !flag_clr) || ev_u;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " wrap.dout"},  32'(dout_w),  32'(m_dout[0]));
    chk({tag, " wrap.oe"},    32'(oe_w),    32'(m_oe[0]));
    chk({tag, " wrap.tc"},    32'(tc_w),    32'(m_tc[0]));
    chk({tag, " wrap.ovf"},   32'(ovf_w),   32'(m_ovf[0]));
    chk({tag, " wrap.unf"},   32'(unf_w),   32'(m_unf[0]));
    chk({tag, " wrap.match"}, 32'(match_w), 32'(m_dout[0] == int'(cmp)));
    chk({tag, " sat.dout"},   32'(dout_s),  32'(m_dout[1]));
    chk({tag, " sat.oe"},     32'(oe_s),    32'(m_oe[1]));
    chk({tag, " sat.tc"},     32'(tc_s),    32'(m_tc[1]));
    chk({tag, " sat.ovf"},    32'(ovf_s),   32'(m_ovf[1]));
    chk({tag, " sat.unf"},    32'(unf_s),   32'(m_unf[1]));
    chk({tag, " sat.match"},  32'(match_s), 32'(m_dout[1] == int'(cmp)));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic async_reset_pulse(input string tag);
    #2 arstn = 1'b0;
    #1 model_reset();
    check_all(tag);
    #2 arstn = 1'b1;
  endtask

  initial begin
    arstn = 1'b0; ltn = 1'b1; upn_down = 1'b0; en = 1'b0; flag_clr = 1'b0;
    load = 4'd0; cmp = 4'd0;
    model_reset();
    #12;
    check_all("reset");
    arstn = 1'b1;

    en = 1'b1; upn_down = 1'b0;
    for (int i = 0; i < 11; i++) step("up_wrap");

    ltn = 1'b0; load = 4'd2; step("load2");
    ltn = 1'b1; upn_down = 1'b1;
    for (int i = 0; i < 4; i++) step("down_wrap");

    ltn = 1'b0; load = 4'd15; step("load_clamp");
    ltn = 1'b1; upn_down = 1'b0;
    for (int i = 0; i < 3; i++) step("sat_up");
    upn_down = 1'b1; step("dir_change");

    ltn = 1'b0; en = 1'b1; load = 4'd5; step("load_beats_en");
    ltn = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) step("hold");
    cmp = 4'd5; #1 check_all("cmp5");
    cmp = 4'd6; #1 check_all("cmp6");
    cmp = 4'd12; #1 check_all("cmp_oor");

    ltn = 1'b0; load = 4'd9; step("load9");
    ltn = 1'b1; en = 1'b1; upn_down = 1'b0; flag_clr = 1'b1; step("clr_vs_set");
    en = 1'b0; step("clr_idle");
    flag_clr = 1'b0;

    ltn = 1'b0; load = 4'd7; step("load7");
    ltn = 1'b1;
    async_reset_pulse("async_rst");
    step("post_rst_idle");
    en = 1'b1; step("post_rst_count");

    for (int i = 0; i < 400; i++) begin
      ltn      = ($urandom_range(0, 7) != 0);
      en       = ($urandom_range(0, 3) != 0);
      upn_down = 1'($urandom_range(0, 1));
      load     = 4'($urandom_range(0, 15));
      cmp      = 4'($urandom_range(0, 15));
      flag_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) async_reset_pulse("rand_rst");
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
